// File: rtl/vga_fb_pkg.sv
// Shared state type and pixel helpers for the frame-buffer arbiter.
`ifndef P_SIZE
`define P_SIZE 19
`endif

package vga_fb_pkg;

  typedef enum logic {CLEAR, RUN} fb_state_t;

  // Helpers work on a widest-case word; callers cast to their real width.
  localparam int MAX_RGB = 16;
  typedef logic [MAX_RGB-1:0]   chan_t;
  typedef logic [3*MAX_RGB-1:0] wpix_t;

  function automatic int pix_w(input int rgb_w);
    return 3 * rgb_w;
  endfunction

  // idx 2 = R (msb), 1 = G, 0 = B
  function automatic chan_t pix_chan(input wpix_t p, input int rgb_w, input int idx);
    wpix_t m;
    m = (wpix_t'(1) << rgb_w) - wpix_t'(1);
    return chan_t'((p >> (idx * rgb_w)) & m);
  endfunction

  function automatic wpix_t pix_pack(input chan_t r, input chan_t g, input chan_t b,
                                     input int rgb_w);
    return (wpix_t'(r) << (2 * rgb_w)) | (wpix_t'(g) << rgb_w) | wpix_t'(b);
  endfunction

endpackage

// File: rtl/vga_fb_clear_seq.sv
// Bring-up sequencer: walks the clear address across the frame buffer,
// then releases vga_sync through a registered vga_start.
`ifndef P_SIZE
`define P_SIZE 19
`endif

module vga_fb_clear_seq
  import vga_fb_pkg::*;
#(
  parameter int NUM_PIXELS = 307200
) (
  input  logic                pixel_clk,
  input  logic                reset,
  output logic                clearing,
  output logic [`P_SIZE-1:0]  clr_addr,
  output logic                vga_start
);

  localparam int AW    = `P_SIZE;
  localparam int CNT_W = $clog2(NUM_PIXELS + 1);

  fb_state_t        state;
  logic [CNT_W-1:0] clr_cnt;

  always_ff @(posedge pixel_clk or posedge reset) begin
    if (reset) begin
      state     <= CLEAR;
      clr_cnt   <= '0;
      vga_start <= 1'b0;
    end else begin
      case (state)
        CLEAR: begin
          clr_cnt <= clr_cnt + 1'b1;
          if (clr_cnt == CNT_W'(NUM_PIXELS - 1)) begin
            state     <= RUN;
            vga_start <= 1'b1;
          end
        end
        default: vga_start <= 1'b1;
      endcase
    end
  end

  assign clearing = (state == CLEAR);
  assign clr_addr = AW'(clr_cnt);

endmodule

// File: rtl/vga_fb_arbiter.sv
// Single-port frame-buffer arbiter: clear at bring-up, then display reads
// win over host accesses; sync/display are delayed to meet the fetched pixel.
`ifndef P_SIZE
`define P_SIZE 19
`endif

module vga_fb_arbiter
  import vga_fb_pkg::*;
#(
  parameter  int                  RGB_WIDTH   = 8,
  parameter  int                  NUM_PIXELS  = 307200,
  localparam int                  PIX_W       = pix_w(RGB_WIDTH),
  parameter  logic [PIX_W-1:0]    CLEAR_VALUE = '0
) (
  input  logic                  pixel_clk,
  input  logic                  reset,
  input  logic                  vga_hsync,
  input  logic                  vga_vsync,
  input  logic                  video_on,
  input  logic [`P_SIZE-1:0]    pixel_addr,
  output logic                  vga_start,
  input  logic                  host_req,
  input  logic                  host_we,
  input  logic [`P_SIZE-1:0]    host_addr,
  input  logic [PIX_W-1:0]      host_wdata,
  output logic                  host_gnt,
  output logic                  host_rvalid,
  output logic [PIX_W-1:0]      host_rdata,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [`P_SIZE-1:0]    mem_addr,
  output logic [PIX_W-1:0]      mem_wdata,
  input  logic [PIX_W-1:0]      mem_rdata,
  output logic [RGB_WIDTH-1:0]  R,
  output logic [RGB_WIDTH-1:0]  G,
  output logic [RGB_WIDTH-1:0]  B,
  output logic                  HSYNC,
  output logic                  VSYNC,
  output logic                  DISPLAY
);

  localparam int AW = `P_SIZE;

  logic          clearing;
  logic [AW-1:0] clr_addr;

  vga_fb_clear_seq #(.NUM_PIXELS(NUM_PIXELS)) u_clr (
    .pixel_clk (pixel_clk),
    .reset     (reset),
    .clearing  (clearing),
    .clr_addr  (clr_addr),
    .vga_start (vga_start)
  );

  logic             disp_rd, host_rd;
  logic [1:0]       rd_tag;   // {disp_rd, host_rd} owning the data now on mem_rdata
  logic [PIX_W-1:0] rdata_q;

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    host_gnt  = 1'b0;
    disp_rd   = 1'b0;
    host_rd   = 1'b0;
    if (clearing) begin
      mem_en    = 1'b1;
      mem_we    = 1'b1;
      mem_addr  = clr_addr;
      mem_wdata = CLEAR_VALUE;
    end else if (video_on) begin
      mem_en   = 1'b1;
      mem_addr = pixel_addr;
      disp_rd  = 1'b1;
    end else if (host_req) begin
      host_gnt  = 1'b1;
      mem_en    = 1'b1;
      mem_we    = host_we;
      mem_addr  = host_addr;
      mem_wdata = host_wdata;
      host_rd   = ~host_we;
    end
  end

  always_ff @(posedge pixel_clk or posedge reset) begin
    if (reset) begin
      rd_tag  <= '0;
      rdata_q <= '0;
      HSYNC   <= 1'b0;
      VSYNC   <= 1'b0;
      DISPLAY <= 1'b0;
    end else begin
      rd_tag  <= {disp_rd, host_rd};
      if (rd_tag[0]) rdata_q <= mem_rdata;
      HSYNC   <= vga_hsync;
      VSYNC   <= vga_vsync;
      DISPLAY <= video_on;
    end
  end

  assign host_rvalid = rd_tag[0];
  assign host_rdata  = rd_tag[0] ? mem_rdata : rdata_q;

  // Tag gate keeps colour dark if a display slot was taken by the clear walk.
  always_comb begin
    R = '0;
    G = '0;
    B = '0;
    if (DISPLAY && rd_tag[1]) begin
      R = RGB_WIDTH'(pix_chan(wpix_t'(mem_rdata), RGB_WIDTH, 2));
      G = RGB_WIDTH'(pix_chan(wpix_t'(mem_rdata), RGB_WIDTH, 1));
      B = RGB_WIDTH'(pix_chan(wpix_t'(mem_rdata), RGB_WIDTH, 0));
    end
  end

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Bench for vga_fb_arbiter: bring-up, table vectors, hand sequences and
// random traffic against a transaction-level model of the frame buffer.
`ifndef P_SIZE
`define P_SIZE 19
`endif

module tb_vga_fb_arbiter;

  localparam int RGBW = 8;
  localparam int PW   = 24;
  localparam int NPIX = 16;
  localparam int AW   = `P_SIZE;
  localparam logic [PW-1:0] CLR = 24'h0000FF;

  logic            pixel_clk = 1'b0;
  logic            reset;
  logic            vga_hsync, vga_vsync, video_on;
  logic [AW-1:0]   pixel_addr;
  logic            vga_start;
  logic            host_req, host_we;
  logic [AW-1:0]   host_addr;
  logic [PW-1:0]   host_wdata;
  logic            host_gnt, host_rvalid;
  logic [PW-1:0]   host_rdata;
  logic            mem_en, mem_we;
  logic [AW-1:0]   mem_addr;
  logic [PW-1:0]   mem_wdata, mem_rdata;
  logic [RGBW-1:0] R, G, B;
  logic            HSYNC, VSYNC, DISPLAY;

  int checks = 0;
  int errors = 0;

  always #5 pixel_clk = ~pixel_clk;

  vga_fb_arbiter #(.RGB_WIDTH(RGBW), .NUM_PIXELS(NPIX), .CLEAR_VALUE(CLR)) dut (
    .pixel_clk(pixel_clk), .reset(reset),
    .vga_hsync(vga_hsync), .vga_vsync(vga_vsync), .video_on(video_on),
    .pixel_addr(pixel_addr), .vga_start(vga_start),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_gnt(host_gnt), .host_rvalid(host_rvalid),
    .host_rdata(host_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .R(R), .G(G), .B(B), .HSYNC(HSYNC), .VSYNC(VSYNC), .DISPLAY(DISPLAY)
  );

  // Single-port memory with 1-cycle read latency
  logic [PW-1:0] env_mem [64];
  always @(posedge pixel_clk) begin
    if (mem_en && mem_addr < AW'(64)) begin
      if (mem_we) env_mem[mem_addr[5:0]] <= mem_wdata;
      else        mem_rdata <= env_mem[mem_addr[5:0]];
    end
  end

  // Reference model: frame contents and what each cycle owes the next one
  logic [PW-1:0] ref_mem [16];
  logic          p_vo, p_hs, p_vs, p_hrd;
  logic [3:0]    p_paddr, p_haddr;
  logic [PW-1:0] last_rd;

  typedef struct {
    logic vo, hs, vs; logic [3:0] paddr;
    logic req, we; logic [3:0] haddr; logic [PW-1:0] wdata;
    logic e_gnt, e_en, e_we; logic [3:0] e_addr;
  } vec_t;
  vec_t vecs [10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_in(input logic vo, input logic hs, input logic vs, input logic [3:0] pa,
                        input logic req, input logic we, input logic [3:0] ha,
                        input logic [PW-1:0] wd);
    video_on = vo; vga_hsync = hs; vga_vsync = vs; pixel_addr = AW'(pa);
    host_req = req; host_we = we; host_addr = AW'(ha); host_wdata = wd;
  endtask

  task automatic model_init();
    for (int i = 0; i < 16; i++) ref_mem[i] = CLR;
    p_vo = 0; p_hs = 0; p_vs = 0; p_hrd = 0; p_paddr = 0; p_haddr = 0;
    last_rd = '0;
  endtask

  // Called at a negedge with inputs set; checks this cycle and advances the model.
  task automatic cyc();
    logic exp_gnt;
    #1;
    chk("DISPLAY", DISPLAY, p_vo);
    chk("HSYNC", HSYNC, p_hs);
    chk("VSYNC", VSYNC, p_vs);
    chk("rgb", {R, G, B}, p_vo ? ref_mem[p_paddr] : 24'h0);
    chk("host_rvalid", host_rvalid, p_hrd);
    if (p_hrd) last_rd = ref_mem[p_haddr];
    chk("host_rdata", host_rdata, last_rd);
    exp_gnt = !video_on && host_req;
    chk("host_gnt", host_gnt, exp_gnt);
    chk("mem_en", mem_en, video_on || host_req);
    if (video_on) begin
      chk("mem_we disp", mem_we, 0);
      chk("mem_addr disp", mem_addr, pixel_addr);
    end else if (host_req) begin
      chk("mem_we host", mem_we, host_we);
      chk("mem_addr host", mem_addr, host_addr);
      if (host_we) chk("mem_wdata host", mem_wdata, host_wdata);
    end
    if (exp_gnt && host_we) ref_mem[host_addr[3:0]] = host_wdata;
    p_vo = video_on; p_hs = vga_hsync; p_vs = vga_vsync;
    p_paddr = pixel_addr[3:0];
    p_hrd = exp_gnt && !host_we;
    p_haddr = host_addr[3:0];
    @(negedge pixel_clk);
  endtask

  // Starts at the negedge reset was released; ends 1 time unit into the first RUN cycle.
  task automatic clear_run();
    for (int c = 0; c < NPIX; c++) begin
      #1;
      chk("clr mem_en", mem_en, 1);
      chk("clr mem_we", mem_we, 1);
      chk("clr mem_addr", mem_addr, c);
      chk("clr mem_wdata", mem_wdata, CLR);
      chk("clr host_gnt", host_gnt, 0);
      chk("clr vga_start", vga_start, 0);
      @(negedge pixel_clk);
    end
    #1;
    chk("vga_start rise", vga_start, 1);
    model_init();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    logic keep;
    vecs[0] = '{0,0,0,4'd0, 1,1,4'd5,24'hAABBCC, 1,1,1,4'd5};
    vecs[1] = '{0,0,0,4'd0, 1,1,4'd7,24'h123456, 1,1,1,4'd7};
    vecs[2] = '{0,0,0,4'd0, 0,0,4'd0,24'h0,      0,0,0,4'd0};
    vecs[3] = '{1,1,0,4'd5, 0,0,4'd0,24'h0,      0,1,0,4'd5};
    vecs[4] = '{1,0,1,4'd7, 1,0,4'd2,24'h0,      0,1,0,4'd7};
    vecs[5] = '{0,0,0,4'd0, 1,0,4'd7,24'h0,      1,1,0,4'd7};
    vecs[6] = '{1,1,1,4'd3, 1,1,4'd3,24'h111111, 0,1,0,4'd3};
    vecs[7] = '{0,0,0,4'd0, 1,1,4'd12,24'h0F0F0F,1,1,1,4'd12};
    vecs[8] = '{1,0,0,4'd12,0,0,4'd0,24'h0,      0,1,0,4'd12};
    vecs[9] = '{0,0,0,4'd0, 0,0,4'd0,24'h0,      0,0,0,4'd0};

    // Reset state, with a host write already pending
    reset = 1'b1;
    set_in(0, 0, 0, 4'd0, 1, 1, 4'd9, 24'h5A5A5A);
    @(negedge pixel_clk); @(negedge pixel_clk); #1;
    chk("rst vga_start", vga_start, 0);
    chk("rst host_gnt", host_gnt, 0);
    chk("rst host_rvalid", host_rvalid, 0);
    chk("rst host_rdata", host_rdata, 0);
    chk("rst rgb", {R, G, B}, 0);
    chk("rst syncs", {HSYNC, VSYNC, DISPLAY}, 0);
    chk("rst mem_addr", mem_addr, 0);
    chk("rst mem_we", mem_we, 1);
    @(negedge pixel_clk);
    reset = 1'b0;
    clear_run();
    for (int i = 0; i < NPIX; i++) chk($sformatf("cleared[%0d]", i), env_mem[i], CLR);
    cyc();   // stalled host write lands on the first RUN cycle
    host_req = 1'b0;

    for (int i = 0; i < 10; i++) begin
      set_in(vecs[i].vo, vecs[i].hs, vecs[i].vs, vecs[i].paddr,
             vecs[i].req, vecs[i].we, vecs[i].haddr, vecs[i].wdata);
      #1;
      chk($sformatf("vec%0d gnt", i), host_gnt, vecs[i].e_gnt);
      chk($sformatf("vec%0d en", i), mem_en, vecs[i].e_en);
      if (vecs[i].e_en) begin
        chk($sformatf("vec%0d we", i), mem_we, vecs[i].e_we);
        chk($sformatf("vec%0d addr", i), mem_addr, vecs[i].e_addr);
      end
      cyc();
    end

    // Display fetch of addr 5
    set_in(1, 1, 1, 4'd5, 0, 0, 4'd0, 24'h0);
    cyc();
    set_in(0, 0, 0, 4'd0, 0, 0, 4'd0, 24'h0);
    #1;
    chk("fetch R", R, 8'hAA);
    chk("fetch G", G, 8'hBB);
    chk("fetch B", B, 8'hCC);
    chk("fetch DISPLAY", DISPLAY, 1);
    chk("fetch HSYNC/VSYNC", {HSYNC, VSYNC}, 2'b11);
    cyc();

    // Host write held through active video, address settling while ungranted
    for (int i = 0; i < 4; i++) begin
      set_in(1, 0, 0, 4'(i), 1, 1, (i < 2) ? 4'd10 : 4'd3, 24'h777777);
      #1;
      chk("prio gnt active", host_gnt, 0);
      cyc();
    end
    set_in(0, 0, 0, 4'd0, 1, 1, 4'd3, 24'h777777);
    #1;
    chk("prio gnt blank", host_gnt, 1);
    chk("prio mem_we", mem_we, 1);
    chk("prio mem_addr", mem_addr, 3);
    cyc();

    // Host read of addr 7, then blanking with stale nonzero mem_rdata
    set_in(0, 0, 0, 4'd0, 1, 0, 4'd7, 24'h0);
    #1;
    chk("hrd gnt", host_gnt, 1);
    cyc();
    set_in(0, 0, 0, 4'd0, 0, 0, 4'd0, 24'h0);
    #1;
    chk("hrd rvalid", host_rvalid, 1);
    chk("hrd rdata", host_rdata, 24'h123456);
    chk("hrd rgb", {R, G, B}, 0);
    cyc();
    #1;
    chk("blank rgb", {R, G, B}, 0);
    chk("blank DISPLAY", DISPLAY, 0);
    chk("blank rdata hold", host_rdata, 24'h123456);
    cyc();

    // Random traffic; an ungranted request stays up
    for (int n = 0; n < 400; n++) begin
      keep = host_req && video_on;
      video_on   = ($urandom_range(0, 2) != 0);
      vga_hsync  = 1'($urandom_range(0, 1));
      vga_vsync  = 1'($urandom_range(0, 1));
      pixel_addr = AW'($urandom_range(0, 15));
      if (!keep) begin
        host_req = 1'($urandom_range(0, 1));
        host_we  = 1'($urandom_range(0, 1));
      end
      host_addr  = AW'($urandom_range(0, 15));
      host_wdata = PW'($urandom);
      cyc();
    end

    // Async reset with a host read in flight
    set_in(0, 1, 1, 4'd0, 1, 0, 4'd7, 24'h0);
    #1;
    chk("rr gnt", host_gnt, 1);
    @(posedge pixel_clk); #1;
    chk("rr rvalid pre", host_rvalid, 1);
    set_in(0, 0, 0, 4'd0, 0, 0, 4'd0, 24'h0);
    reset = 1'b1;
    #1;
    chk("rr rvalid", host_rvalid, 0);
    chk("rr rdata", host_rdata, 0);
    chk("rr syncs", {HSYNC, VSYNC, DISPLAY}, 0);
    chk("rr rgb", {R, G, B}, 0);
    chk("rr vga_start", vga_start, 0);
    chk("rr mem_addr", mem_addr, 0);
    @(negedge pixel_clk); @(negedge pixel_clk);
    reset = 1'b0;

    // Reset again once clr_cnt reaches 9
    for (int c = 0; c < 9; c++) @(negedge pixel_clk);
    #1;
    chk("mc addr9", mem_addr, 9);
    #1;
    reset = 1'b1;
    #1;
    chk("mc addr0", mem_addr, 0);
    chk("mc vga_start", vga_start, 0);
    chk("mc rvalid", host_rvalid, 0);
    @(negedge pixel_clk);
    reset = 1'b0;
    clear_run();
    set_in(1, 0, 0, 4'd9, 0, 0, 4'd0, 24'h0);
    cyc();
    set_in(0, 0, 0, 4'd0, 0, 0, 4'd0, 24'h0);
    cyc();
    cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
